// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: completion record type, FU completion side,
// issue stalls and the registered CDB broadcast.
package cdb_pkg;

  // Completion record carried from an FU to the CDB, including RVFI fields.
  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
  } cdb_t;

endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4
);
  import cdb_pkg::*;

  localparam int SW = $clog2(NUM_FU);

  logic              flush;
  logic [NUM_FU-1:0] fu_complete_valid;
  cdb_t              fu_complete_data [NUM_FU];
  logic [NUM_FU-1:0] fu_stall;
  logic              cdb_valid;
  cdb_t              cdb_data;
  logic [SW-1:0]     cdb_src;
  logic              overflow_err;

  // FU / pipeline-control side.
  modport master (
    output flush, fu_complete_valid, fu_complete_data,
    input  fu_stall, cdb_valid, cdb_data, cdb_src, overflow_err
  );

  // Arbiter side.
  modport slave (
    input  flush, fu_complete_valid, fu_complete_data,
    output fu_stall, cdb_valid, cdb_data, cdb_src, overflow_err
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Completion-side CDB arbiter: every FU result is captured into a per-FU queue
// (or bypassed when that queue is empty), one candidate per cycle is granted
// round-robin and broadcast on a registered CDB. Per-FU stalls keep one slot
// free for the result each FU may already have in flight.
// Optional simulation checkers are compiled in when CDB_ARBITER_CHECK_EN is defined.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  import cdb_pkg::*;

  localparam int SW = $clog2(NUM_FU);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(FIFO_DEPTH - 1);

  logic [NUM_FU-1:0] cand_valid;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] drop;
  logic [NUM_FU-1:0] wr_en;
  cdb_t              cand_data [NUM_FU];
  logic [CW-1:0]     count_reg [NUM_FU];

  logic              grant_valid;
  logic [SW-1:0]     grant_idx;
  cdb_t              grant_data;
  logic [SW-1:0]     rr_ptr_reg;
  logic [SW-1:0]     rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
      cdb_t          mem [FIFO_DEPTH];
      logic [PW-1:0] rd_ptr_reg;
      logic [PW-1:0] wr_ptr_reg;
      logic          queue_empty;
      logic          granted;

      assign queue_empty = (count_reg[gi] == '0);
      assign granted     = grant_valid && (grant_idx == SW'(gi));

      // Queue head wins over the incoming record so per-FU order is kept.
      assign cand_valid[gi] = !queue_empty || (bus.fu_complete_valid[gi] && !bus.flush);
      assign cand_data[gi]  = queue_empty ? bus.fu_complete_data[gi] : mem[rd_ptr_reg];

      assign pop[gi]   = !bus.flush && granted && !queue_empty;
      // An incoming record goes into the queue unless it was bypassed straight out.
      assign push[gi]  = bus.fu_complete_valid[gi] && !bus.flush && !(granted && queue_empty);
      assign drop[gi]  = push[gi] && (count_reg[gi] == FULL_CNT) && !pop[gi];
      assign wr_en[gi] = push[gi] && !drop[gi];

      // Stall looks only at the registered count, never at this cycle's push/pop.
      assign bus.fu_stall[gi] = (count_reg[gi] >= STALL_CNT);

      // Pointer and occupancy bookkeeping; flush empties the queue.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_ptr_reg    <= '0;
          wr_ptr_reg    <= '0;
          count_reg[gi] <= '0;
        end else if (bus.flush) begin
          rd_ptr_reg    <= '0;
          wr_ptr_reg    <= '0;
          count_reg[gi] <= '0;
        end else begin
          if (wr_en[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])   rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg[gi] <= count_reg[gi] + CW'(wr_en[gi]) - CW'(pop[gi]);
        end
      end

      // Queue storage; contents need no reset because the count guards them.
      always_ff @(posedge clk) begin
        if (wr_en[gi]) mem[wr_ptr_reg] <= bus.fu_complete_data[gi];
      end
    end
  endgenerate

  // Round-robin search starting at rr_ptr_reg; first valid candidate wins.
  always_comb begin
    int            idx;
    logic [SW-1:0] idx_sel;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_sel     = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      idx = int'(rr_ptr_reg) + off;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      idx_sel = SW'(idx);
      if (!grant_valid && cand_valid[idx_sel]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_sel;
      end
    end
  end

  // Granted record and the pointer that follows the winner.
  always_comb begin
    grant_data = cand_data[grant_idx];
    rr_next    = rr_ptr_reg;
    if (grant_valid) begin
      rr_next = (int'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Registered CDB broadcast and round-robin pointer; flush suppresses the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_data  <= '0;
      bus.cdb_src   <= '0;
      rr_ptr_reg    <= '0;
    end else if (bus.flush) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_data  <= '0;
    end else if (grant_valid) begin
      bus.cdb_valid <= 1'b1;
      bus.cdb_data  <= grant_data;
      bus.cdb_src   <= grant_idx;
      rr_ptr_reg    <= rr_next;
    end else begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_data  <= '0;
    end
  end

  // Sticky error flag for any dropped result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.overflow_err <= 1'b0;
    end else if (|drop) begin
      bus.overflow_err <= 1'b1;
    end
  end

`ifdef CDB_ARBITER_CHECK_EN
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_chk
      // Flag dropped results and pulses into a full, non-draining queue.
      always @(posedge clk) begin
        if (!rst) begin
          assert (!drop[gi])
            else $error("cdb_arbiter: result dropped on FU %0d", gi);
          assert (!(bus.fu_complete_valid[gi] && !bus.flush &&
                    (count_reg[gi] == FULL_CNT) && !pop[gi]))
            else $error("cdb_arbiter: FU %0d completed into a full queue", gi);
        end
      end
    end
  endgenerate

  // Broadcast valid must always be known once out of reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(bus.cdb_valid))
        else $error("cdb_arbiter: cdb_valid is unknown");
    end
  end
`else
  // Checkers not compiled; datapath, drop behaviour and overflow_err are unchanged.
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (NUM_FU=4, FIFO_DEPTH=2).
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  cdb_arbiter_if #(.NUM_FU(4)) bus ();

  cdb_arbiter #(.NUM_FU(4), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinctive record so any field corruption shows up.
  function automatic cdb_t mk(input int fu, input logic [31:0] d);
    cdb_t r;
    r.order     = 64'(d) + 64'h100;
    r.inst      = {d[19:0], 12'h013};
    r.pc        = 32'h8000_0000 + (d << 2);
    r.rd        = 5'(fu + 1);
    r.data      = d;
    r.rs1_rdata = ~d;
    r.rs2_rdata = d ^ 32'h5a5a_5a5a;
    return r;
  endfunction

  // FU i pulses with data {tag, i} when v[i] is set.
  task automatic drive(input logic [3:0] v, input int tag);
    for (int i = 0; i < 4; i++) begin
      bus.fu_complete_valid[i] = v[i];
      bus.fu_complete_data[i]  = v[i] ? mk(i, 32'((tag << 4) | i)) : '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.flush = 1'b0;
    drive(4'b0000, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    $display("txn reset: valid=%b src=%0d ovf=%b stall=%b", bus.cdb_valid, bus.cdb_src, bus.overflow_err, bus.fu_stall);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.cdb_data); end
    n_cmp++; if (bus.cdb_src !== 2'd0) begin n_bad++; $display("FAIL reset_src: got %0d want 0", bus.cdb_src); end
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_err); end
    n_cmp++; if (bus.fu_stall !== 4'b0000) begin n_bad++; $display("FAIL reset_stall: got %b want 0000", bus.fu_stall); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    bus.fu_complete_valid[0] = 1'b1;
    bus.fu_complete_data[0]  = mk(0, 32'h0000_0005);
    @(negedge clk);
    drive(4'b0000, 0);
    $display("txn bypass: valid=%b src=%0d data=%h", bus.cdb_valid, bus.cdb_src, bus.cdb_data.data);
    n_cmp++; if (bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL bypass_valid: got %b want 1", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_data.data !== 32'h5) begin n_bad++; $display("FAIL bypass_data: got %h want 5", bus.cdb_data.data); end
    n_cmp++; if (bus.cdb_src !== 2'd0) begin n_bad++; $display("FAIL bypass_src: got %0d want 0", bus.cdb_src); end
    @(negedge clk);
    $display("txn bypass_after: valid=%b", bus.cdb_valid);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL bypass_idle: got %b want 0", bus.cdb_valid); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_stall [4];
    exp_stall = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    do_reset();
    drive(4'b1111, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(4'b0000, 0);
      $display("txn all_four %0d: valid=%b src=%0d data=%h stall=%b", k, bus.cdb_valid, bus.cdb_src, bus.cdb_data.data, bus.fu_stall);
      n_cmp++; if (bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL all_four_valid[%0d]: got %b want 1", k, bus.cdb_valid); end
      n_cmp++; if (bus.cdb_src !== 2'(k)) begin n_bad++; $display("FAIL all_four_src[%0d]: got %0d want %0d", k, bus.cdb_src, k); end
      n_cmp++; if (bus.cdb_data !== mk(k, 32'(16 + k))) begin n_bad++; $display("FAIL all_four_data[%0d]: got %h want %h", k, bus.cdb_data, mk(k, 32'(16 + k))); end
      n_cmp++; if (bus.fu_stall !== exp_stall[k]) begin n_bad++; $display("FAIL all_four_stall[%0d]: got %b want %b", k, bus.fu_stall, exp_stall[k]); end
    end
    @(negedge clk);
    $display("txn all_four_end: valid=%b", bus.cdb_valid);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL all_four_idle: got %b want 0", bus.cdb_valid); end
  endtask

  // FU0 pulses cycles 1-4, FU2 cycles 1-3; grants alternate and FU2 stays in order.
  task automatic test_fairness();
    logic [3:0] stim [8];
    logic       exp_v [8];
    logic [1:0] exp_s [8];
    int         exp_t [8];
    stim  = '{4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_s = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
    exp_t = '{1, 1, 2, 2, 3, 3, 4, 0};
    do_reset();
    drive(stim[0], 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      $display("txn fairness %0d: valid=%b src=%0d data=%h", k, bus.cdb_valid, bus.cdb_src, bus.cdb_data.data);
      n_cmp++; if (bus.cdb_valid !== exp_v[k]) begin n_bad++; $display("FAIL fair_valid[%0d]: got %b want %b", k, bus.cdb_valid, exp_v[k]); end
      if (exp_v[k]) begin
        n_cmp++; if (bus.cdb_src !== exp_s[k]) begin n_bad++; $display("FAIL fair_src[%0d]: got %0d want %0d", k, bus.cdb_src, exp_s[k]); end
        n_cmp++; if (bus.cdb_data !== mk(int'(exp_s[k]), 32'((exp_t[k] << 4) | int'(exp_s[k])))) begin n_bad++; $display("FAIL fair_data[%0d]: got %h", k, bus.cdb_data.data); end
      end
      if (k < 7) drive(stim[k + 1], k + 2);
    end
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++; $display("FAIL fair_ovf: got %b want 0", bus.overflow_err); end
  endtask

  // FU1 pulses three times while losing; the third record is dropped.
  task automatic test_overflow();
    logic [3:0] stim [7];
    logic       exp_v [7];
    logic [1:0] exp_s [7];
    int         exp_t [7];
    logic       exp_o [7];
    stim  = '{4'b0010, 4'b1110, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_s = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd0};
    exp_t = '{1, 2, 2, 3, 2, 3, 0};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    drive(stim[0], 1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      $display("txn overflow %0d: valid=%b src=%0d data=%h ovf=%b", k, bus.cdb_valid, bus.cdb_src, bus.cdb_data.data, bus.overflow_err);
      n_cmp++; if (bus.cdb_valid !== exp_v[k]) begin n_bad++; $display("FAIL ovf_valid[%0d]: got %b want %b", k, bus.cdb_valid, exp_v[k]); end
      if (exp_v[k]) begin
        n_cmp++; if (bus.cdb_src !== exp_s[k]) begin n_bad++; $display("FAIL ovf_src[%0d]: got %0d want %0d", k, bus.cdb_src, exp_s[k]); end
        n_cmp++; if (bus.cdb_data !== mk(int'(exp_s[k]), 32'((exp_t[k] << 4) | int'(exp_s[k])))) begin n_bad++; $display("FAIL ovf_data[%0d]: got %h", k, bus.cdb_data.data); end
      end
      n_cmp++; if (bus.overflow_err !== exp_o[k]) begin n_bad++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, bus.overflow_err, exp_o[k]); end
      if (k < 6) drive(stim[k + 1], k + 2);
    end
  endtask

  task automatic test_flush();
    do_reset();
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_bad++; $display("FAIL flush_ovf_cleared: got %b want 0", bus.overflow_err); end
    drive(4'b0111, 1);
    @(negedge clk);
    $display("txn flush_pre: valid=%b src=%0d stall=%b", bus.cdb_valid, bus.cdb_src, bus.fu_stall);
    n_cmp++; if (bus.fu_stall !== 4'b0110) begin n_bad++; $display("FAIL flush_pre_stall: got %b want 0110", bus.fu_stall); end
    bus.flush = 1'b1;
    drive(4'b1000, 2);
    @(negedge clk);
    bus.flush = 1'b0;
    drive(4'b0000, 0);
    $display("txn flush: valid=%b stall=%b", bus.cdb_valid, bus.fu_stall);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_data !== '0) begin n_bad++; $display("FAIL flush_data: got %h want 0", bus.cdb_data); end
    n_cmp++; if (bus.fu_stall !== 4'b0000) begin n_bad++; $display("FAIL flush_stall: got %b want 0000", bus.fu_stall); end
    @(negedge clk);
    $display("txn flush_after: valid=%b", bus.cdb_valid);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_replay: got %b want 0", bus.cdb_valid); end
    // rr pointer held at 1 across the flush, so FU2 beats FU0.
    drive(4'b0101, 3);
    @(negedge clk);
    drive(4'b0000, 0);
    $display("txn flush_rr: valid=%b src=%0d data=%h", bus.cdb_valid, bus.cdb_src, bus.cdb_data.data);
    n_cmp++; if (bus.cdb_src !== 2'd2 || bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL flush_rr_src: got %0d/%b want 2/1", bus.cdb_src, bus.cdb_valid); end
    n_cmp++; if (bus.cdb_data !== mk(2, 32'h32)) begin n_bad++; $display("FAIL flush_rr_data: got %h", bus.cdb_data.data); end
    @(negedge clk);
    $display("txn flush_rr2: valid=%b src=%0d data=%h", bus.cdb_valid, bus.cdb_src, bus.cdb_data.data);
    n_cmp++; if (bus.cdb_src !== 2'd0 || bus.cdb_data !== mk(0, 32'h30)) begin n_bad++; $display("FAIL flush_rr_second: got src %0d data %h", bus.cdb_src, bus.cdb_data.data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(4'b1111, 1);
    @(negedge clk);
    drive(4'b0000, 0);
    n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.fu_stall !== 4'b1110) begin n_bad++; $display("FAIL areset_pre: got valid %b stall %b want 1/1110", bus.cdb_valid, bus.fu_stall); end
    #2 rst = 1'b1;
    #1;
    $display("txn async_reset: valid=%b src=%0d stall=%b", bus.cdb_valid, bus.cdb_src, bus.fu_stall);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_data !== '0) begin n_bad++; $display("FAIL areset_data: got %h want 0", bus.cdb_data); end
    n_cmp++; if (bus.fu_stall !== 4'b0000) begin n_bad++; $display("FAIL areset_stall: got %b want 0000", bus.fu_stall); end
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0100, 5);
    @(negedge clk);
    drive(4'b0000, 0);
    $display("txn post_reset: valid=%b src=%0d data=%h", bus.cdb_valid, bus.cdb_src, bus.cdb_data.data);
    n_cmp++; if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd2) begin n_bad++; $display("FAIL post_reset_grant: got %b/%0d want 1/2", bus.cdb_valid, bus.cdb_src); end
    n_cmp++; if (bus.cdb_data !== mk(2, 32'h52)) begin n_bad++; $display("FAIL post_reset_data: got %h", bus.cdb_data.data); end
    @(negedge clk);
    $display("txn post_reset_idle: valid=%b", bus.cdb_valid);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got %b want 0", bus.cdb_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    drive(4'b0000, 0);
    test_reset();
    test_bypass();
    test_all_four();
    test_fairness();
    test_overflow();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side arbiter between the functional units and the common data bus (CDB). Each FU (ALU, multiplier, LSU, …) presents its result through the `complete_valid`/`complete_data` half of its FU interface for exactly one cycle and has no backpressure. This block captures every result into a per-FU queue. It picks one result per cycle with round-robin arbitration and drives a registered CDB toward the scoreboard and register file. It also asserts a per-FU stall toward issue logic so that no queue can overflow.

## Interface
- `NUM_FU`, default 4: number of FU completion ports; valid range 2–8.
- `FIFO_DEPTH`, default 2: entries per FU queue; power of two, at least 2.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `flush` input, 1: pipeline flush, synchronous, same cycle as the FU flush.
- `fu_complete_valid` input, [NUM_FU]: per-FU result valid, one-cycle pulse.
- `fu_complete_data` input, cdb_t [NUM_FU]: per-FU completion record (`rd`, `data`, `pc`, `inst`, `order`, RVFI fields).
- `fu_stall` output, [NUM_FU]: per-FU issue block; combinational from the queue count.
- `cdb_valid` output, 1: broadcast valid, registered.
- `cdb_data` output, cdb_t: broadcast record, registered.
- `cdb_src` output, $clog2(NUM_FU): index of the FU that sourced the current broadcast, registered.
- `overflow_err` output, 1: sticky; set when a result is dropped.

## Operation
- Per-FU queue: circular FIFO with read pointer, write pointer and count.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - The count width holds the value `FIFO_DEPTH`.
- Candidate for FU i:
  - If queue i is non-empty, the candidate is the queue head.
  - If queue i is empty and `fu_complete_valid[i]` is high, the incoming record is the candidate (bypass).
  - Bypass is only taken when the queue is empty, so per-FU completion order is preserved.
- Arbitration: round-robin over all valid candidates.
  - Search starts at `rr_ptr`.
  - After any grant to FU g, `rr_ptr` becomes (g+1) mod `NUM_FU`.
  - With no grant, `rr_ptr` holds.
- Granted candidate:
  - Loaded into `cdb_data`/`cdb_src` with `cdb_valid`=1 at the next edge.
  - If it came from the queue head, the queue pops.
- Ungranted incoming result for FU i: pushed into queue i.
- A queue can push and pop in the same cycle. Net count change is 0 and both pointers advance.
- Overflow: a push to a full queue that is not popping that cycle.
  - The incoming record is dropped.
  - `overflow_err` is set to 1 and stays set until `rst`.
- `fu_stall[i]` = (count_i ≥ `FIFO_DEPTH`−1).
  - This reserves one slot for the single result each FU may already have in flight.
  - With this rule, overflow cannot occur when FUs respect `fu_stall`.
- No-grant cycle: `cdb_valid` ← 0 and `cdb_data` ← '0.
- `flush` high:
  - All queues are emptied (pointers and counts ← 0).
  - `fu_complete_valid` inputs are ignored that cycle.
  - `cdb_valid` ← 0 at the edge.
  - `rr_ptr` holds.
  - `overflow_err` holds.

## Timing
- Reset values:
  - `cdb_valid`=0, `cdb_data`='0, `cdb_src`=0, `overflow_err`=0.
  - `fu_stall`=all 0.
  - `rr_ptr`=0; all queues empty.
  - Reset is asserted asynchronously and takes effect immediately, including in the middle of a burst.
- Latency:
  - A result pulsed in cycle t with no contention gives `cdb_valid`=1 in cycle t+1 (bypass).
  - A queued result is broadcast no earlier than one cycle after its push.
- Throughput: exactly one broadcast per cycle while any candidate exists.
- Starvation bound: a valid queue head is granted within `NUM_FU` cycles.
- Simultaneous events:
  - `flush` takes priority over grant and push.
  - `rst` takes priority over everything.
- `fu_stall` reflects the count at the start of the cycle; it is not a function of the current cycle's push/pop.

## Configuration
- `CDB_ARBITER_CHECK_EN`, when defined, compiles in simulation checkers:
  - An immediate assertion with `$error` on any overflow.
  - An assertion that `fu_complete_valid[i]` is never high while queue i is full and not popping.
  - An assertion that `cdb_valid` is never X after reset deassertion.
- Undefined: no checkers are compiled. Datapath behaviour is identical, including the drop and `overflow_err`.

## Test plan
- Single FU 0 pulses `data`=0x0000_0005 in cycle 3 with no contention -> `cdb_valid`=1, `cdb_data.data`=0x5, `cdb_src`=0 in cycle 4; `cdb_valid`=0 in cycle 5.
- All 4 FUs pulse in the same cycle with `rr_ptr`=0:
  - Broadcasts in cycles t+1..t+4 come from FUs 0,1,2,3.
  - `fu_stall[1]`, `fu_stall[2]` and `fu_stall[3]` are high while each holds one entry (`FIFO_DEPTH`=2).
- FU 2 pulses in consecutive cycles while FU 0 floods every cycle:
  - FU 2's results are broadcast in pulse order.
  - Neither FU waits more than 4 cycles.
- FU 1 ignores `fu_stall` and pulses 3 times while losing arbitration -> the third record is dropped and `overflow_err`=1 stays set after the queue drains.
- `flush` with 2 entries queued and an incoming pulse -> next cycle `cdb_valid`=0, all counts 0, `fu_stall`=0; the dropped records are never broadcast.
- Assert `rst` asynchronously between clock edges while mid-burst -> outputs go immediately to their reset values; the first pulse after deassertion is broadcast with 1-cycle latency.
